flash_programmer: RTL and testbench

Sequencer that sits directly upstream of the flash driver and turns a stream of 16-bit words into flash command sequences. For a run of words starting at a flash word address it erases each block before first use, writes each word, reads it back to verify, and reports completion or the first failure. It is the block the UART/boot-update path uses to reprogram on-board flash.

---
 rtl/flash_programmer_if.sv | 47 ++++
 rtl/flash_programmer.sv | 228 ++++++++++++++++++++++
 tb/tb_flash_programmer.sv | 337 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/flash_programmer_if.sv
// flash_programmer_if: run control, word stream and flash driver bus.
// master = programmer side, slave = host/driver side.
interface flash_programmer_if #(
  parameter int FLASH_ADDR_SIZE = 22
);
  logic                       start;
  logic [FLASH_ADDR_SIZE-1:0] base_addr;
  logic [FLASH_ADDR_SIZE-1:0] word_count;
  logic [15:0]                in_data;
  logic                       in_valid;
  logic                       in_ready;
  logic                       active;
  logic                       done;
  logic [1:0]                 err_code;
  logic [FLASH_ADDR_SIZE-1:0] err_addr;
  logic [FLASH_ADDR_SIZE-1:0] drv_addr;
  logic [15:0]                drv_data_in;
  logic [15:0]                drv_data_out;
  logic                       drv_enable_read;
  logic                       drv_enable_erase;
  logic                       drv_enable_write;
  logic                       drv_busy;

  modport master (
    input  start, base_addr, word_count,
    input  in_data, in_valid,
    input  drv_data_out, drv_busy,
    output in_ready, active, done,
    output err_code, err_addr,
    output drv_addr, drv_data_in,
    output drv_enable_read,
    output drv_enable_erase,
    output drv_enable_write
  );

  modport slave (
    output start, base_addr, word_count,
    output in_data, in_valid,
    output drv_data_out, drv_busy,
    input  in_ready, active, done,
    input  err_code, err_addr,
    input  drv_addr, drv_data_in,
    input  drv_enable_read,
    input  drv_enable_erase,
    input  drv_enable_write
  );
endinterface

// File: rtl/flash_programmer.sv
// flash_programmer: erase/write/verify sequencer feeding the flash driver.
// Ports: clk, rst (async, active high), bus (flash_programmer_if.master):
//   start/base_addr/word_count run control, in_data/in_valid/in_ready
//   word stream, active/done/err_code/err_addr status, drv_* driver bus.
module flash_programmer #(
  parameter int FLASH_ADDR_SIZE = 22,
  parameter int BLOCK_ADDR_BITS = 16,
  parameter int TIMEOUT_CYCLES  = 67108864
) (
  input  logic               clk,
  input  logic               rst,
  flash_programmer_if.master bus
);

  localparam int AW = FLASH_ADDR_SIZE;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [AW-1:0] A_ONE  = AW'(1);
  localparam logic [TW-1:0] T_ONE  = TW'(1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [3:0] {
    IDLE,
    FETCH,
    ER_ISSUE,
    ER_HI,
    ER_LO,
    WR_ISSUE,
    WR_HI,
    WR_LO,
    RD_REQ,
    RD_HI,
    RD_LO,
    RD_SAMPLE,
    GAP,
    FINISH
  } state_t;

  state_t        r_state;
  logic [AW-1:0] r_cur_addr;
  logic [AW-1:0] r_remaining;
  logic [15:0]   r_word;
  logic          r_first;
  logic [TW-1:0] r_timer;
  logic          r_gap;
  logic          r_in_ready;
  logic          r_active;
  logic          r_done;
  logic [1:0]    r_err_code;
  logic [AW-1:0] r_err_addr;
  logic [AW-1:0] r_drv_addr;
  logic [15:0]   r_drv_data_in;
  logic          r_en_rd;
  logic          r_en_er;
  logic          r_en_wr;

  logic   w_blk_start;
  logic   w_addr_max;
  logic   w_last;
  logic   w_timeout;
  logic   w_hi_state;
  logic   w_wait_met;
  state_t w_wait_next;

  assign w_blk_start =
    (r_cur_addr[BLOCK_ADDR_BITS-1:0] == '0);
  assign w_addr_max = &r_cur_addr;
  assign w_last     = (r_remaining == A_ONE);
  assign w_timeout  = (r_timer == T_LAST);

  // HI states wait for busy to rise, LO states for it to fall
  assign w_hi_state = (r_state == ER_HI) ||
                      (r_state == WR_HI) ||
                      (r_state == RD_HI);
  assign w_wait_met = w_hi_state ? bus.drv_busy
                                 : !bus.drv_busy;

  always_comb begin
    w_wait_next = FINISH;
    unique case (r_state)
      ER_HI:   w_wait_next = ER_LO;
      ER_LO:   w_wait_next = WR_ISSUE;
      WR_HI:   w_wait_next = WR_LO;
      WR_LO:   w_wait_next = RD_REQ;
      RD_HI:   w_wait_next = RD_LO;
      RD_LO:   w_wait_next = RD_SAMPLE;
      default: w_wait_next = FINISH;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= IDLE;
      r_cur_addr    <= '0;
      r_remaining   <= '0;
      r_word        <= '0;
      r_first       <= 1'b0;
      r_timer       <= '0;
      r_gap         <= 1'b0;
      r_in_ready    <= 1'b0;
      r_active      <= 1'b0;
      r_done        <= 1'b0;
      r_err_code    <= 2'd0;
      r_err_addr    <= '0;
      r_drv_addr    <= '0;
      r_drv_data_in <= '0;
      r_en_rd       <= 1'b0;
      r_en_er       <= 1'b0;
      r_en_wr       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          // a busy driver may still be finishing an aborted run
          if (bus.start && !bus.drv_busy) begin
            r_err_code  <= 2'd0;
            r_err_addr  <= '0;
            r_cur_addr  <= bus.base_addr;
            r_remaining <= bus.word_count;
            r_first     <= 1'b1;
            if (bus.word_count == '0) begin
              r_done  <= 1'b1;
              r_state <= FINISH;
            end else begin
              r_active   <= 1'b1;
              r_in_ready <= 1'b1;
              r_state    <= FETCH;
            end
          end
        end
        FETCH: begin
          if (bus.in_valid) begin
            r_word        <= bus.in_data;
            r_drv_data_in <= bus.in_data;
            r_drv_addr    <= r_cur_addr;
            r_in_ready    <= 1'b0;
            if (r_first || w_blk_start) begin
              r_en_er <= 1'b1;
              r_state <= ER_ISSUE;
            end else begin
              r_en_wr <= 1'b1;
              r_state <= WR_ISSUE;
            end
          end
        end
        ER_ISSUE: begin
          r_en_er <= 1'b0;
          r_timer <= '0;
          r_state <= ER_HI;
        end
        WR_ISSUE: begin
          r_en_wr <= 1'b0;
          r_timer <= '0;
          r_state <= WR_HI;
        end
        RD_REQ: begin
          r_timer <= '0;
          r_state <= RD_HI;
        end
        ER_HI, ER_LO, WR_HI, WR_LO, RD_HI, RD_LO: begin
          if (w_wait_met) begin
            r_timer <= '0;
            r_state <= w_wait_next;
            if (r_state == ER_LO) r_en_wr <= 1'b1;
            if (r_state == WR_LO) r_en_rd <= 1'b1;
          end else if (w_timeout) begin
            r_err_code <= 2'd1;
            r_err_addr <= r_cur_addr;
            r_en_rd    <= 1'b0;
            r_en_er    <= 1'b0;
            r_en_wr    <= 1'b0;
            r_active   <= 1'b0;
            r_done     <= 1'b1;
            r_state    <= FINISH;
          end else begin
            r_timer <= r_timer + T_ONE;
          end
        end
        RD_SAMPLE: begin
          if (bus.drv_data_out != r_word) begin
            r_err_code <= 2'd2;
            r_err_addr <= r_cur_addr;
          end
          r_en_rd <= 1'b0;
          r_gap   <= 1'b0;
          r_state <= GAP;
        end
        GAP: begin
          if (!r_gap) begin
            r_gap <= 1'b1;
          end else if (r_err_code != 2'd0 || w_last) begin
            r_active <= 1'b0;
            r_done   <= 1'b1;
            r_state  <= FINISH;
          end else if (w_addr_max) begin
            r_err_code <= 2'd3;
            r_err_addr <= r_cur_addr;
            r_active   <= 1'b0;
            r_done     <= 1'b1;
            r_state    <= FINISH;
          end else begin
            r_cur_addr  <= r_cur_addr + A_ONE;
            r_remaining <= r_remaining - A_ONE;
            r_first     <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= FETCH;
          end
        end
        FINISH: begin
          r_active <= 1'b0;
          r_state  <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready         = r_in_ready;
  assign bus.active           = r_active;
  assign bus.done             = r_done;
  assign bus.err_code         = r_err_code;
  assign bus.err_addr         = r_err_addr;
  assign bus.drv_addr         = r_drv_addr;
  assign bus.drv_data_in      = r_drv_data_in;
  assign bus.drv_enable_read  = r_en_rd;
  assign bus.drv_enable_erase = r_en_er;
  assign bus.drv_enable_write = r_en_wr;

endmodule

// File: tb/tb_flash_programmer.sv
// tb_flash_programmer: flash_programmer against a behavioural flash
// driver model; expected command streams are queued per run.
module tb_flash_programmer;

  localparam int ER_LAT = 12;
  localparam int WR_LAT = 8;
  localparam int RD_LAT = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  flash_programmer_if #(.FLASH_ADDR_SIZE(22)) bus();

  flash_programmer #(
    .FLASH_ADDR_SIZE(22),
    .BLOCK_ADDR_BITS(16),
    .TIMEOUT_CYCLES(100)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // ---------------- flash driver model ----------------
  typedef struct packed {
    logic [1:0]  op;
    logic [21:0] addr;
    logic [15:0] data;
    logic [31:0] t;
  } ev_t;

  ev_t         obs[$];
  logic [15:0] mem[logic [21:0]];
  logic        m_busy = 1'b0;
  logic [15:0] m_dout = 16'h0;
  int          m_cnt = 0;
  logic [1:0]  m_op = 2'd0;
  logic [21:0] m_addr = 22'h0;
  logic        m_rd_prev = 1'b0;
  bit          m_hang = 1'b0;
  bit          cor_en = 1'b0;
  logic [21:0] cor_addr = 22'h0;
  int          cyc = 0;
  int          ir_viol = 0;

  assign bus.drv_busy     = m_busy;
  assign bus.drv_data_out = m_dout;

  function automatic logic [15:0] rdval(input logic [21:0] a);
    if (cor_en && a == cor_addr) return 16'hFFFF;
    if (mem.exists(a)) return mem[a];
    return 16'hFFFF;
  endfunction

  always @(posedge clk) begin : model
    logic [21:0] dk[$];
    cyc++;
    m_rd_prev <= bus.drv_enable_read;
    if (bus.in_ready && m_busy) ir_viol++;
    if (m_cnt > 0) begin
      if (!(m_hang && m_op == 2'd2)) begin
        if (m_cnt == 1) begin
          m_busy <= 1'b0;
          if (m_op == 2'd3) m_dout <= rdval(m_addr);
        end
        m_cnt--;
      end
    end else if (bus.drv_enable_erase) begin
      obs.push_back({2'd1, bus.drv_addr, 16'h0, 32'(cyc)});
      dk.delete();
      foreach (mem[k])
        if (k[21:16] == bus.drv_addr[21:16]) dk.push_back(k);
      foreach (dk[i]) mem.delete(dk[i]);
      m_op = 2'd1;
      m_cnt = ER_LAT;
      m_busy <= 1'b1;
    end else if (bus.drv_enable_write) begin
      obs.push_back({2'd2, bus.drv_addr, bus.drv_data_in, 32'(cyc)});
      mem[bus.drv_addr] = bus.drv_data_in;
      m_op = 2'd2;
      m_cnt = WR_LAT;
      m_busy <= 1'b1;
    end else if (bus.drv_enable_read && !m_rd_prev) begin
      obs.push_back({2'd3, bus.drv_addr, 16'h0, 32'(cyc)});
      m_addr = bus.drv_addr;
      m_op = 2'd3;
      m_cnt = RD_LAT;
      m_busy <= 1'b1;
    end
  end

  // ---------------- vectors ----------------
  typedef struct {
    logic [21:0]      base;
    int               count;
    logic [3:0][15:0] w;
    bit               cor;
    logic [21:0]      caddr;
    bit               hang;
    logic [1:0]       eerr;
    logic [21:0]      eaddr;
    int               ewr;
    int               eer;
  } vec_t;

  vec_t vecs[6];

  task automatic wait_idle();
    int c;
    c = 0;
    while (m_busy && c < 300) begin
      @(negedge clk);
      c++;
    end
    if (m_busy) begin
      checks++;
      errors++;
      $display("FAIL wait_idle: busy stuck got 1 expected 0");
    end
  endtask

  task automatic do_start(input logic [21:0] b, input logic [21:0] n);
    @(negedge clk);
    bus.base_addr  = b;
    bus.word_count = n;
    bus.start      = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    ev_t         ex[$];
    ev_t         got[$];
    logic [21:0] a;
    int          p0, idx, nrd, nex, tdone;
    bit          hs, fin;
    wait_idle();
    cor_en   = v.cor;
    cor_addr = v.caddr;
    m_hang   = v.hang;
    for (int i = 0; i < v.ewr; i++) begin
      a = v.base + 22'(i);
      if (i == 0 || a[15:0] == 16'h0)
        ex.push_back({2'd1, a, 16'h0, 32'h0});
      ex.push_back({2'd2, a, v.w[i], 32'h0});
    end
    nex = ex.size();
    p0 = obs.size();
    do_start(v.base, 22'(v.count));
    if (v.count == 0)
      chk({nm, "_done_next_cycle"}, bus.done, 1'b1);
    else
      chk({nm, "_fetch_ready"}, {bus.active, bus.in_ready}, 2'b11);
    fin = bus.done;
    idx = 0;
    for (int c = 0; c < 3000 && !fin; c++) begin
      bus.in_valid = (idx < v.count);
      bus.in_data  = (idx < 4) ? v.w[idx] : 16'h0;
      hs = bus.in_valid && bus.in_ready;
      @(posedge clk);
      if (hs) idx++;
      @(negedge clk);
      fin = bus.done;
    end
    bus.in_valid = 1'b0;
    tdone = cyc;
    chk({nm, "_done_seen"}, fin, 1'b1);
    chk({nm, "_err_code"}, bus.err_code, v.eerr);
    chk({nm, "_err_addr"}, bus.err_addr, v.eaddr);
    chk({nm, "_active_low"}, bus.active, 1'b0);
    if (v.hang) begin
      chk({nm, "_enables_low"},
          {bus.drv_enable_read, bus.drv_enable_erase,
           bus.drv_enable_write}, 3'b000);
    end
    nrd = 0;
    for (int j = p0; j < obs.size(); j++) begin
      if (obs[j].op == 2'd3) nrd++;
      else got.push_back(obs[j]);
    end
    chk({nm, "_n_cmds"}, got.size(), nex);
    chk({nm, "_n_erases"}, nex - v.ewr, v.eer);
    chk({nm, "_n_reads"}, nrd, v.hang ? v.ewr - 1 : v.ewr);
    while (ex.size() > 0 && got.size() > 0) begin
      ev_t e, g;
      e = ex.pop_front();
      g = got.pop_front();
      chk($sformatf("%s_cmd_%0d", nm, nex - ex.size() - 1),
          {g.op, g.addr, g.data}, {e.op, e.addr, e.data});
      if (v.hang && g.op == 2'd2) begin
        chk({nm, "_timeout_latency"},
            (tdone - int'(g.t) >= 98) && (tdone - int'(g.t) <= 106),
            1'b1);
      end
    end
    @(negedge clk);
    chk({nm, "_done_one_cycle"}, bus.done, 1'b0);
    if (v.eerr == 2'd0) begin
      for (int i = 0; i < v.count && i < 4; i++) begin
        a = v.base + 22'(i);
        chk($sformatf("%s_mem_%0d", nm, i),
            mem.exists(a) ? {1'b0, mem[a]} : 17'h1_0000,
            {1'b0, v.w[i]});
      end
    end
  endtask

  initial begin
    int  p0;
    bit  seen;
    vec_t rv;

    bus.start      = 1'b0;
    bus.base_addr  = 22'h0;
    bus.word_count = 22'h0;
    bus.in_data    = 16'h0;
    bus.in_valid   = 1'b0;

    vecs[0] = '{base: 22'h000000, count: 3,
                w: {16'h0, 16'h9ABC, 16'h5678, 16'h1234},
                cor: 0, caddr: 22'h0, hang: 0,
                eerr: 2'd0, eaddr: 22'h0, ewr: 3, eer: 1};
    vecs[1] = '{base: 22'h00FFFE, count: 4,
                w: {16'hD00D, 16'hC0DE, 16'hBEAD, 16'hA5A5},
                cor: 0, caddr: 22'h0, hang: 0,
                eerr: 2'd0, eaddr: 22'h0, ewr: 4, eer: 2};
    vecs[2] = '{base: 22'h000000, count: 3,
                w: {16'h0, 16'h9ABC, 16'h5678, 16'h1234},
                cor: 1, caddr: 22'h000001, hang: 0,
                eerr: 2'd2, eaddr: 22'h000001, ewr: 2, eer: 1};
    vecs[3] = '{base: 22'h3FFFFF, count: 2,
                w: {16'h0, 16'h0, 16'h2222, 16'h1111},
                cor: 0, caddr: 22'h0, hang: 0,
                eerr: 2'd3, eaddr: 22'h3FFFFF, ewr: 1, eer: 1};
    vecs[4] = '{base: 22'h000010, count: 0,
                w: {16'h0, 16'h0, 16'h0, 16'h0},
                cor: 0, caddr: 22'h0, hang: 0,
                eerr: 2'd0, eaddr: 22'h0, ewr: 0, eer: 0};
    vecs[5] = '{base: 22'h000020, count: 2,
                w: {16'h0, 16'h0, 16'h7777, 16'h6666},
                cor: 0, caddr: 22'h0, hang: 1,
                eerr: 2'd1, eaddr: 22'h000020, ewr: 1, eer: 1};

    repeat (3) @(negedge clk);
    chk("reset_ctrl",
        {bus.in_ready, bus.active, bus.done, bus.err_code,
         bus.drv_enable_read, bus.drv_enable_erase,
         bus.drv_enable_write}, 8'h00);
    chk("reset_addr",
        {bus.err_addr, bus.drv_addr, bus.drv_data_in}, 60'h0);
    rst = 1'b0;
    @(negedge clk);

    for (int k = 0; k < 6; k++)
      run_vec(vecs[k], $sformatf("vec%0d", k));
    m_hang = 1'b0;

    // reset while the write is outstanding
    wait_idle();
    cor_en = 1'b0;
    p0 = obs.size();
    bus.in_data  = 16'hBEEF;
    bus.in_valid = 1'b1;
    do_start(22'h000040, 22'd1);
    seen = 1'b0;
    for (int c = 0; c < 200 && !seen; c++) begin
      @(negedge clk);
      seen = (obs.size() > p0 + 1) && (obs[obs.size()-1].op == 2'd2);
    end
    bus.in_valid = 1'b0;
    chk("rstrun_write_seen", seen, 1'b1);
    if (obs.size() > p0 + 1) begin
      chk("rstrun_erase", {obs[p0].op, obs[p0].addr},
          {2'd1, 22'h000040});
      chk("rstrun_write", {obs[p0+1].op, obs[p0+1].addr,
          obs[p0+1].data}, {2'd2, 22'h000040, 16'hBEEF});
    end
    @(negedge clk);
    chk("rstrun_in_wr_lo", {bus.active, m_busy}, 2'b11);
    rst = 1'b1;
    #1;
    chk("rstrun_ctrl_zero",
        {bus.in_ready, bus.active, bus.done, bus.err_code,
         bus.drv_enable_read, bus.drv_enable_erase,
         bus.drv_enable_write}, 8'h00);
    chk("rstrun_addr_zero",
        {bus.err_addr, bus.drv_addr, bus.drv_data_in}, 60'h0);
    @(negedge clk);
    rst = 1'b0;

    // start while the driver is still busy must be ignored
    bus.base_addr  = 22'h000080;
    bus.word_count = 22'd2;
    bus.start      = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    chk("busy_start_precond", m_busy, 1'b1);
    chk("busy_start_ignored",
        {bus.active, bus.in_ready, bus.done}, 3'b000);
    @(negedge clk);
    chk("busy_start_still_idle", bus.active, 1'b0);

    rv = '{base: 22'h000080, count: 2,
           w: {16'h0, 16'h0, 16'h5555, 16'hAAAA},
           cor: 0, caddr: 22'h0, hang: 0,
           eerr: 2'd0, eaddr: 22'h0, ewr: 2, eer: 1};
    run_vec(rv, "recover");

    chk("in_ready_never_with_busy", ir_viol, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
